// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single-port instruction memory. It shares the memory between
// instruction fetch and a program loader, and screens bad fetches before they reach memory.
module imem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_err,
  input  logic                  load_req,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_gnt,
  output logic                  load_rvalid,
  output logic [DATA_WIDTH-1:0] load_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned       CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {
    WIN_FETCH = 1'b0,
    WIN_LOAD  = 1'b1
  } winner_e;

  winner_e          last_winner_q, last_winner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic fetch_rvalid_q;
  logic fetch_bad_q;
  logic load_rvalid_q;

  logic fetch_bad_c;
  logic fetch_mem_req_c;
  logic load_win_c;
  logic fetch_win_c;

  // Word index only; the loader's byte offset and upper bits are dropped silently.
  logic unused_load_addr_c;
  assign unused_load_addr_c = ^{load_addr[1:0], load_addr[ADDR_WIDTH-1:MEM_AW+2]};

  // A bad fetch never occupies the memory slot.
  assign fetch_bad_c     = (fetch_addr[1:0] != 2'b00) ||
                           (|fetch_addr[ADDR_WIDTH-1:MEM_AW+2]);
  assign fetch_mem_req_c = fetch_req && !fetch_bad_c;

  // Arbitration state: who last used the memory and the current loader run length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner_q <= WIN_FETCH;
      burst_cnt_q   <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  // Slot arbitration, grants, memory drive and next-state.
  always_comb begin
    last_winner_d = last_winner_q;
    burst_cnt_d   = '0;
    load_win_c    = 1'b0;
    fetch_win_c   = 1'b0;
    fetch_gnt     = 1'b0;
    load_gnt      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    if (reset) begin
      if (load_req && (!fetch_mem_req_c ||
                       (last_winner_q == WIN_FETCH) ||
                       (burst_cnt_q < BURST_MAX))) begin
        load_win_c = 1'b1;
      end else if (fetch_mem_req_c) begin
        fetch_win_c = 1'b1;
      end

      load_gnt  = load_win_c;
      fetch_gnt = fetch_req && (fetch_bad_c || fetch_win_c);

      if (load_win_c) begin
        mem_en        = 1'b1;
        mem_we        = load_we;
        mem_addr      = load_addr[MEM_AW+1:2];
        mem_wdata     = load_wdata;
        last_winner_d = WIN_LOAD;
        if (burst_cnt_q < BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else if (fetch_win_c) begin
        mem_en        = 1'b1;
        mem_addr      = fetch_addr[MEM_AW+1:2];
        last_winner_d = WIN_FETCH;
      end
    end
  end

  // Response tags: they steer mem_rdata to the requester one cycle after its grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_rvalid_q <= 1'b0;
      fetch_bad_q    <= 1'b0;
      load_rvalid_q  <= 1'b0;
    end else begin
      fetch_rvalid_q <= fetch_req && fetch_gnt;
      fetch_bad_q    <= fetch_req && fetch_gnt && fetch_bad_c;
      load_rvalid_q  <= load_win_c && !load_we;
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign fetch_err    = fetch_rvalid_q && fetch_bad_q;
  assign fetch_rdata  = (fetch_rvalid_q && !fetch_bad_q) ? mem_rdata : '0;
  assign load_rvalid  = load_rvalid_q;
  assign load_rdata   = load_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter. It pairs a behavioural slot-history model with a
// synchronous memory model, and uses directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_imem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned MAW   = 8;
  localparam int unsigned MB    = 4;
  localparam int unsigned DEPTH = 1 << MAW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [DW-1:0] fetch_rdata;
  logic          load_req = 1'b0, load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_wdata = '0;
  logic          load_gnt, load_rvalid;
  logic [DW-1:0] load_rdata;
  logic          mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory the arbiter drives.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } resp_t;

  resp_t         fq[$];
  resp_t         lq[$];
  int            hist[$];          // per-cycle slot owner: 0 idle, 1 fetch, 2 loader
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            fetch_rv_cnt = 0;
  int            load_rv_cnt = 0;
  logic          fg_m, lg_m;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pop the expected response whenever the DUT presents one.
  always @(posedge clk) begin
    resp_t r;
    #2;
    cyc++;
    if (fetch_rvalid) begin
      fetch_rv_cnt++;
      if (fq.size() == 0) chk("fetch_rvalid_unexpected", 64'(fetch_rvalid), 64'd0);
      else begin
        r = fq.pop_front();
        chk("fetch_latency", 64'(cyc), 64'(r.due));
        chk("fetch_rdata", 64'(fetch_rdata), 64'(r.data));
        chk("fetch_err", 64'(fetch_err), 64'(r.err));
      end
    end else if (fq.size() != 0 && fq[0].due <= cyc) begin
      chk("fetch_rvalid_missing", 64'(fetch_rvalid), 64'd1);
      void'(fq.pop_front());
    end
    if (load_rvalid) begin
      load_rv_cnt++;
      if (lq.size() == 0) chk("load_rvalid_unexpected", 64'(load_rvalid), 64'd0);
      else begin
        r = lq.pop_front();
        chk("load_latency", 64'(cyc), 64'(r.due));
        chk("load_rdata", 64'(load_rdata), 64'(r.data));
      end
    end else if (lq.size() != 0 && lq[0].due <= cyc) begin
      chk("load_rvalid_missing", 64'(load_rvalid), 64'd1);
      void'(lq.pop_front());
    end
  end

  // Drive one cycle of requests, check grants/memory drive against the model, queue responses.
  task automatic step(input logic fr, input logic [AW-1:0] fa, input logic lr,
                      input logic lwe, input logic [AW-1:0] la, input logic [DW-1:0] lwd);
    logic fbad, fmem, all_l, elg, efg, emem;
    resp_t r;
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa;
    load_req = lr; load_we = lwe; load_addr = la; load_wdata = lwd;
    #1;
    fbad  = (fa[1:0] != 2'b00) || ((fa >> (MAW + 2)) != '0);
    fmem  = fr && !fbad;
    // Fetch only beats a contending loader once the loader has owned the last MB slots in a row.
    all_l = (hist.size() >= MB);
    if (all_l) for (int i = 0; i < MB; i++) if (hist[hist.size() - 1 - i] != 2) all_l = 1'b0;
    elg  = reset && lr && (!fmem || !all_l);
    efg  = reset && fr && (fbad || !elg);
    emem = elg || (efg && !fbad);
    chk("fetch_gnt", 64'(fetch_gnt), 64'(efg));
    chk("load_gnt", 64'(load_gnt), 64'(elg));
    chk("mem_en", 64'(mem_en), 64'(emem));
    chk("mem_we", 64'(mem_we), 64'(elg && lwe));
    if (emem) chk("mem_addr", 64'(mem_addr), elg ? 64'(la[MAW+1:2]) : 64'(fa[MAW+1:2]));
    if (elg && lwe) chk("mem_wdata", 64'(mem_wdata), 64'(lwd));
    if (!reset) begin
      chk("rst_fetch_rvalid", 64'(fetch_rvalid), 64'd0);
      chk("rst_fetch_err", 64'(fetch_err), 64'd0);
      chk("rst_fetch_rdata", 64'(fetch_rdata), 64'd0);
      chk("rst_load_rvalid", 64'(load_rvalid), 64'd0);
      chk("rst_load_rdata", 64'(load_rdata), 64'd0);
    end else begin
      if (efg) begin
        r.due = cyc + 1; r.err = fbad; r.data = fbad ? '0 : ref_mem[fa[MAW+1:2]];
        fq.push_back(r);
      end
      if (elg && !lwe) begin
        r.due = cyc + 1; r.err = 1'b0; r.data = ref_mem[la[MAW+1:2]];
        lq.push_back(r);
      end
      if (elg && lwe) ref_mem[la[MAW+1:2]] = lwd;
      hist.push_back(elg ? 2 : (emem ? 1 : 0));
      if (hist.size() > 16) void'(hist.pop_front());
    end
    fg_m = efg;
    lg_m = elg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic enter_reset();
    reset = 1'b0;
    fq.delete(); lq.delete(); hist.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    fetch_req = 1'b0; load_req = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]   patb;
    int            f0, l0;
    logic          f_pend, l_pend, l_we;
    logic [AW-1:0] f_a, l_a;
    logic [DW-1:0] l_d;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
    end
    ref_mem[0] = 32'h13; ref_mem[1] = 32'h93; ref_mem[2] = 32'h113;
    for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];

    // Reset with both requesters active: everything must stay quiet.
    enter_reset();
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, '0);
    step(1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 32'h55);
    release_reset();

    // Back-to-back aligned fetches.
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0); chk("seq_gnt0", 64'(fetch_gnt), 64'd1);
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0); chk("seq_gnt1", 64'(fetch_gnt), 64'd1);
    step(1'b1, 32'h8, 1'b0, 1'b0, '0, '0); chk("seq_gnt2", 64'(fetch_gnt), 64'd1);
    idle(2);

    // Misaligned and out-of-range fetches.
    step(1'b1, 32'h6, 1'b0, 1'b0, '0, '0);   chk("mis_mem_en", 64'(mem_en), 64'd0);
    step(1'b1, 32'h400, 1'b0, 1'b0, '0, '0); chk("oor_mem_en", 64'(mem_en), 64'd0);
    idle(2);

    // Loader write then fetch of the same word.
    step(1'b0, '0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    idle(2);

    // Sustained contention: burst limit pattern.
    f0 = fetch_rv_cnt; l0 = load_rv_cnt; patb = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, '0);
      patb[i] = fetch_gnt;
    end
    idle(2);
    chk("burst_pattern", 64'(patb), 64'h210);
    chk("burst_fetch_rv", 64'(fetch_rv_cnt - f0), 64'd2);
    chk("burst_load_rv", 64'(load_rv_cnt - l0), 64'd10);

    // Bad fetch and loader write share a cycle.
    step(1'b1, 32'h2, 1'b1, 1'b1, 32'h30, 32'hCAFE0001);
    chk("share_fgnt", 64'(fetch_gnt), 64'd1);
    chk("share_lgnt", 64'(load_gnt), 64'd1);
    idle(2);

    // Reset the cycle after a loader read grant discards its response.
    step(1'b0, '0, 1'b1, 1'b0, 32'h10, '0);
    @(posedge clk); #1;
    enter_reset();
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h8, '0);
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    release_reset();
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0); chk("post_rst_gnt", 64'(fetch_gnt), 64'd1);
    idle(2);

    // Random traffic with hold-until-grant and occasional withdrawal.
    f_pend = 1'b0; l_pend = 1'b0; f_a = '0; l_a = '0; l_we = 1'b0; l_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (f_pend && $urandom_range(0, 99) < 8) f_pend = 1'b0;
      else if (!f_pend && $urandom_range(0, 99) < 55) begin
        f_pend = 1'b1;
        f_a = AW'($urandom_range(0, 31)) << 2;
        case ($urandom_range(0, 19))
          0, 1:    f_a = f_a | AW'($urandom_range(1, 3));
          2:       f_a = f_a | (AW'(1) << $urandom_range(MAW + 2, AW - 1));
          default: ;
        endcase
      end
      if (l_pend && $urandom_range(0, 99) < 8) l_pend = 1'b0;
      else if (!l_pend && $urandom_range(0, 99) < 60) begin
        l_pend = 1'b1;
        l_we = $urandom_range(0, 1) == 1;
        l_d  = $urandom;
        l_a  = (AW'($urandom_range(0, 31)) << 2) | AW'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) l_a = l_a | ($urandom & 32'hFFFF_FC00);
      end
      step(f_pend, f_a, l_pend, l_we, l_a, l_d);
      if (fg_m) f_pend = 1'b0;
      if (lg_m) l_pend = 1'b0;
    end
    idle(3);
    chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
    chk("load_queue_drained", 64'(lq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
